id_exe_register: RTL and testbench

Pipeline register between the decode (ID) stage and the execute (EXE) stage of the ARM core. It captures every decoded field on each rising clock edge. It presents those fields to EXE: the shift-operand/immediate path (Val2 generation), the ALU, the branch-target adder and the status logic. It supports a hold (freeze) for memory stalls, a flush (bubble insert) for taken branches, and a valid bit marking whether the EXE slot holds a real instruction.

---
 rtl/id_exe_register.sv | 163 ++++++++++++++++
 tb/tb_id_exe_register.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_register.sv
// id_exe_register
// ID/EXE pipeline register of the ARM core. Every decoded field from the
// decode stage is captured on the rising clock edge and presented to the
// execute stage (Val2 generation, ALU, branch-target adder, status logic).
//
// Control behaviour, highest priority first:
//   rstN low (async) -> every output 0
//   flush            -> bubble: every field 0, validOut 0 (wins over freeze)
//   freeze           -> every field, including validOut, holds
//   otherwise        -> every field loads its input, validOut <= validIn
//
// No field is transformed here; shifting, sign extension and immediate
// expansion all happen in EXE. The memory-instruction flag for Val2 is
// memReadOut|memWriteOut downstream, so it has no field of its own.
//
// Optional feature macro: ID_EXE_FWD_EN
//   When defined, the source register numbers src1/src2 are carried for the
//   forwarding unit under the same reset/flush/freeze rules. A bubble zeroes
//   them; the forwarding unit qualifies them with validOut. When undefined,
//   those ports and flops do not exist.

module id_exe_register (
  input  logic        clk,
  input  logic        rstN,
  input  logic        freeze,
  input  logic        flush,
  input  logic        validIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] valRnIn,
  input  logic [31:0] valRmIn,
  input  logic [11:0] shiftOperandIn,
  input  logic        immIn,
  input  logic [23:0] signedImm24In,
  input  logic [3:0]  destIn,
  input  logic [3:0]  exeCmdIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic        wbEnIn,
  input  logic        bIn,
  input  logic        sIn,
  input  logic [3:0]  statusIn,
`ifdef ID_EXE_FWD_EN
  input  logic [3:0]  src1In,
  input  logic [3:0]  src2In,
`endif
  output logic [31:0] pcOut,
  output logic [31:0] valRnOut,
  output logic [31:0] valRmOut,
  output logic [11:0] shiftOperandOut,
  output logic        immOut,
  output logic [23:0] signedImm24Out,
  output logic [3:0]  destOut,
  output logic [3:0]  exeCmdOut,
  output logic        memReadOut,
  output logic        memWriteOut,
  output logic        wbEnOut,
  output logic        bOut,
  output logic        sOut,
  output logic [3:0]  statusOut,
`ifdef ID_EXE_FWD_EN
  output logic [3:0]  src1Out,
  output logic [3:0]  src2Out,
`endif
  output logic        validOut
);

  // All captured fields grouped so that a bubble is simply the all-zero value
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] valRn;
    logic [31:0] valRm;
    logic [11:0] shiftOperand;
    logic        imm;
    logic [23:0] signedImm24;
    logic [3:0]  dest;
    logic [3:0]  exeCmd;
    logic        memRead;
    logic        memWrite;
    logic        wbEn;
    logic        b;
    logic        s;
    logic [3:0]  status;
`ifdef ID_EXE_FWD_EN
    logic [3:0]  src1;
    logic [3:0]  src2;
`endif
  } stage_t;

  stage_t stageIn;
  stage_t stage_d;
  stage_t stage_q;
  logic   valid_d;
  logic   valid_q;

  // Gather the decoded inputs into one record
  always_comb begin
    stageIn              = '0;
    stageIn.pc           = pcIn;
    stageIn.valRn        = valRnIn;
    stageIn.valRm        = valRmIn;
    stageIn.shiftOperand = shiftOperandIn;
    stageIn.imm          = immIn;
    stageIn.signedImm24  = signedImm24In;
    stageIn.dest         = destIn;
    stageIn.exeCmd       = exeCmdIn;
    stageIn.memRead      = memReadIn;
    stageIn.memWrite     = memWriteIn;
    stageIn.wbEn         = wbEnIn;
    stageIn.b            = bIn;
    stageIn.s            = sIn;
    stageIn.status       = statusIn;
`ifdef ID_EXE_FWD_EN
    stageIn.src1         = src1In;
    stageIn.src2         = src2In;
`endif
  end

  // Next-state selection: flush beats freeze, freeze beats a normal load
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (flush) begin
      stage_d = '0;
      valid_d = 1'b0;
    end else if (!freeze) begin
      stage_d = stageIn;
      valid_d = validIn;
    end
  end

  // The pipeline flops themselves; asynchronous reset clears to a bubble
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from the flops, no input reaches them combinationally
  assign pcOut           = stage_q.pc;
  assign valRnOut        = stage_q.valRn;
  assign valRmOut        = stage_q.valRm;
  assign shiftOperandOut = stage_q.shiftOperand;
  assign immOut          = stage_q.imm;
  assign signedImm24Out  = stage_q.signedImm24;
  assign destOut         = stage_q.dest;
  assign exeCmdOut       = stage_q.exeCmd;
  assign memReadOut      = stage_q.memRead;
  assign memWriteOut     = stage_q.memWrite;
  assign wbEnOut         = stage_q.wbEn;
  assign bOut            = stage_q.b;
  assign sOut            = stage_q.s;
  assign statusOut       = stage_q.status;
`ifdef ID_EXE_FWD_EN
  assign src1Out         = stage_q.src1;
  assign src2Out         = stage_q.src2;
`endif
  assign validOut        = valid_q;

endmodule

// File: tb/tb_id_exe_register.sv
// tb_id_exe_register
// Self-checking bench for id_exe_register. A behavioural model holds the
// expected contents of the EXE slot as one flat vector: cleared by reset or
// flush, kept while frozen, otherwise replaced by the ID-side values.
// Build with ID_EXE_FWD_EN defined to include the src1/src2 fields.

module tb_id_exe_register;

`ifdef ID_EXE_FWD_EN
  localparam int VecW = 159;
`else
  localparam int VecW = 151;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        freeze;
  logic        flush;
  logic        validIn;
  logic [31:0] pcIn;
  logic [31:0] valRnIn;
  logic [31:0] valRmIn;
  logic [11:0] shiftOperandIn;
  logic        immIn;
  logic [23:0] signedImm24In;
  logic [3:0]  destIn;
  logic [3:0]  exeCmdIn;
  logic        memReadIn;
  logic        memWriteIn;
  logic        wbEnIn;
  logic        bIn;
  logic        sIn;
  logic [3:0]  statusIn;
  logic [3:0]  src1In;
  logic [3:0]  src2In;

  logic [31:0] pcOut;
  logic [31:0] valRnOut;
  logic [31:0] valRmOut;
  logic [11:0] shiftOperandOut;
  logic        immOut;
  logic [23:0] signedImm24Out;
  logic [3:0]  destOut;
  logic [3:0]  exeCmdOut;
  logic        memReadOut;
  logic        memWriteOut;
  logic        wbEnOut;
  logic        bOut;
  logic        sOut;
  logic [3:0]  statusOut;
  logic [3:0]  src1Out;
  logic [3:0]  src2Out;
  logic        validOut;

  logic [VecW-1:0] expVec;
  int vectors = 0;
  int miscompares = 0;

  id_exe_register dut (
    .clk             (clk),
    .rstN            (rstN),
    .freeze          (freeze),
    .flush           (flush),
    .validIn         (validIn),
    .pcIn            (pcIn),
    .valRnIn         (valRnIn),
    .valRmIn         (valRmIn),
    .shiftOperandIn  (shiftOperandIn),
    .immIn           (immIn),
    .signedImm24In   (signedImm24In),
    .destIn          (destIn),
    .exeCmdIn        (exeCmdIn),
    .memReadIn       (memReadIn),
    .memWriteIn      (memWriteIn),
    .wbEnIn          (wbEnIn),
    .bIn             (bIn),
    .sIn             (sIn),
    .statusIn        (statusIn),
`ifdef ID_EXE_FWD_EN
    .src1In          (src1In),
    .src2In          (src2In),
`endif
    .pcOut           (pcOut),
    .valRnOut        (valRnOut),
    .valRmOut        (valRmOut),
    .shiftOperandOut (shiftOperandOut),
    .immOut          (immOut),
    .signedImm24Out  (signedImm24Out),
    .destOut         (destOut),
    .exeCmdOut       (exeCmdOut),
    .memReadOut      (memReadOut),
    .memWriteOut     (memWriteOut),
    .wbEnOut         (wbEnOut),
    .bOut            (bOut),
    .sOut            (sOut),
    .statusOut       (statusOut),
`ifdef ID_EXE_FWD_EN
    .src1Out         (src1Out),
    .src2Out         (src2Out),
`endif
    .validOut        (validOut)
  );

`ifndef ID_EXE_FWD_EN
  assign src1Out = 4'd0;
  assign src2Out = 4'd0;
`endif

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Everything ID presents, flattened in a fixed order
  function automatic logic [VecW-1:0] packIn();
    return {validIn, pcIn, valRnIn, valRmIn, shiftOperandIn, immIn, signedImm24In,
            destIn, exeCmdIn, memReadIn, memWriteIn, wbEnIn, bIn, sIn, statusIn
`ifdef ID_EXE_FWD_EN
            , src1In, src2In
`endif
           };
  endfunction

  // Everything EXE sees, flattened in the same order
  function automatic logic [VecW-1:0] packOut();
    return {validOut, pcOut, valRnOut, valRmOut, shiftOperandOut, immOut, signedImm24Out,
            destOut, exeCmdOut, memReadOut, memWriteOut, wbEnOut, bOut, sOut, statusOut
`ifdef ID_EXE_FWD_EN
            , src1Out, src2Out
`endif
           };
  endfunction

  // Random decoded instruction on the ID side
  task automatic applyStimulus();
    validIn        = 1'($urandom);
    pcIn           = $urandom;
    valRnIn        = $urandom;
    valRmIn        = $urandom;
    shiftOperandIn = 12'($urandom);
    immIn          = 1'($urandom);
    signedImm24In  = 24'($urandom);
    destIn         = 4'($urandom);
    exeCmdIn       = 4'($urandom);
    memReadIn      = 1'($urandom);
    memWriteIn     = 1'($urandom);
    wbEnIn         = 1'($urandom);
    bIn            = 1'($urandom);
    sIn            = 1'($urandom);
    statusIn       = 4'($urandom);
    src1In         = 4'($urandom);
    src2In         = 4'($urandom);
  endtask

  // Drive every ID-side bit to one
  task automatic driveAllOnes();
    validIn = 1'b1; pcIn = '1; valRnIn = '1; valRmIn = '1; shiftOperandIn = '1;
    immIn = 1'b1; signedImm24In = '1; destIn = '1; exeCmdIn = '1;
    memReadIn = 1'b1; memWriteIn = 1'b1; wbEnIn = 1'b1; bIn = 1'b1; sIn = 1'b1;
    statusIn = '1; src1In = '1; src2In = '1;
  endtask

  // One clock: update the model with what ID presented at the edge, then
  // return on the falling edge where outputs are sampled
  task automatic tick();
    @(posedge clk);
    if (!rstN)        expVec = '0;
    else if (flush)   expVec = '0;
    else if (!freeze) expVec = packIn();
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rstN = 1'b1; freeze = 1'b0; flush = 1'b0;
    driveAllOnes();
    tick();
    #2 rstN = 1'b0;
    expVec = '0;
    #1;
    vectors++;
    if (packOut() !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h want 0", packOut());
    end
    #3 rstN = 1'b1;
    @(negedge clk);
    vectors++;
    if (packOut() !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_until_edge: got %h want 0", packOut());
    end
    tick();
    vectors++;
    if (validOut !== 1'b1 || packOut() !== expVec) begin
      miscompares++;
      $display("[TB] FAIL reset_release_load: got %h want %h", packOut(), expVec);
    end
  endtask

  task automatic test_pass_through();
    $display("[TB] test_pass_through");
    applyStimulus();
    validIn = 1'b1; valRmIn = 32'h8000_0001; shiftOperandIn = 12'h0C3;
    immIn = 1'b0; exeCmdIn = 4'b0010; wbEnIn = 1'b1;
    tick();
    vectors++;
    if (valRmOut !== 32'h8000_0001 || shiftOperandOut !== 12'h0C3 || immOut !== 1'b0 ||
        exeCmdOut !== 4'b0010 || wbEnOut !== 1'b1 || validOut !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pass_fields: valRm %h shOp %h imm %b cmd %b wb %b v %b",
               valRmOut, shiftOperandOut, immOut, exeCmdOut, wbEnOut, validOut);
    end
    vectors++;
    if (packOut() !== expVec) begin
      miscompares++;
      $display("[TB] FAIL pass_all: got %h want %h", packOut(), expVec);
    end
    applyStimulus();
    #1;
    vectors++;
    if (packOut() !== expVec) begin
      miscompares++;
      $display("[TB] FAIL no_comb_path: got %h want %h", packOut(), expVec);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] pcSeq [3];
    $display("[TB] test_freeze");
    pcSeq[0] = 32'h14; pcSeq[1] = 32'h18; pcSeq[2] = 32'h1C;
    applyStimulus();
    validIn = 1'b1; pcIn = 32'h10;
    tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      pcIn = pcSeq[i];
      tick();
      vectors++;
      if (pcOut !== 32'h10 || packOut() !== expVec) begin
        miscompares++;
        $display("[TB] FAIL freeze_hold%0d: pc %h want 10, got %h want %h",
                 i, pcOut, packOut(), expVec);
      end
    end
    freeze = 1'b0;
    tick();
    vectors++;
    if (pcOut !== 32'h1C || packOut() !== expVec) begin
      miscompares++;
      $display("[TB] FAIL freeze_release: pc %h want 1c", pcOut);
    end
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    applyStimulus();
    wbEnIn = 1'b1; memWriteIn = 1'b1; bIn = 1'b1; validIn = 1'b1;
    tick();
    flush = 1'b1;
    applyStimulus();
    wbEnIn = 1'b1; memWriteIn = 1'b1; bIn = 1'b1; validIn = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (packOut() !== '0 || validOut !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_bubble: got %h want 0", packOut());
    end
  endtask

  task automatic test_flush_freeze();
    $display("[TB] test_flush_freeze");
    applyStimulus();
    validIn = 1'b1; wbEnIn = 1'b1;
    tick();
    flush = 1'b1; freeze = 1'b1;
    applyStimulus();
    tick();
    flush = 1'b0;
    vectors++;
    if (packOut() !== '0) begin
      miscompares++;
      $display("[TB] FAIL flush_freeze_bubble: got %h want 0", packOut());
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      validIn = 1'b1; wbEnIn = 1'b1;
      tick();
      vectors++;
      if (packOut() !== '0 || validOut !== 1'b0 || wbEnOut !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bubble_frozen%0d: got %h want 0", i, packOut());
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_forwarding();
`ifdef ID_EXE_FWD_EN
    $display("[TB] test_forwarding");
    applyStimulus();
    src1In = 4'd3; src2In = 4'd7;
    tick();
    vectors++;
    if (src1Out !== 4'd3 || src2Out !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL fwd_src_load: got %0d/%0d want 3/7", src1Out, src2Out);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (src1Out !== 4'd0 || src2Out !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL fwd_src_flush: got %0d/%0d want 0/0", src1Out, src2Out);
    end
`endif
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 6) == 0);
      tick();
      vectors++;
      if (packOut() !== expVec) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h want %h", i, packOut(), expVec);
      end
    end
    freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    $display("[TB] test_reset_midstream");
    applyStimulus();
    validIn = 1'b1;
    tick();
    #3 rstN = 1'b0;
    expVec = '0;
    #1;
    vectors++;
    if (packOut() !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %h want 0", packOut());
    end
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus();
    validIn = 1'b1;
    tick();
    vectors++;
    if (packOut() !== expVec || validOut !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_reload: got %h want %h", packOut(), expVec);
    end
  endtask

  initial begin
    rstN = 1'b0; freeze = 1'b0; flush = 1'b0;
    applyStimulus();
    expVec = '0;
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_freeze();
    test_flush();
    test_flush_freeze();
    test_forwarding();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
